// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the fetch PC, runs one outstanding imem transaction at a time
// and holds a single fetched instruction for the decode pipeline register.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic [31:0] load_pc,
    input  logic        stall_fetch,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        imem_err,
    output logic        fetch_valid,
    output logic [31:0] fetch_instruction,
    output logic [31:0] fetch_pc,
    output logic [31:0] fetch_pc_plus4,
    output logic        fetch_adel,
    output logic        fetch_ibe,
    output logic        instruction_memory_busy
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDrop} state_e;

    state_e      state;
    logic [31:0] pc;
    logic [31:0] req_pc;
    logic        pc_misaligned;
    logic        consume;
    logic        buffer_free;

    assign pc_misaligned = (pc[1:0] != 2'b00);
    assign consume       = fetch_valid && !stall_fetch;
    assign buffer_free   = !fetch_valid || consume;

    // A misaligned PC never reaches the bus; it is reported as an address error.
    assign imem_req  = (state == StReq) && !pc_misaligned;
    assign imem_addr = pc;

    assign fetch_pc_plus4          = fetch_pc + 32'd4;
    assign instruction_memory_busy = ~fetch_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= StIdle;
            pc                <= RESET_PC;
            req_pc            <= 32'd0;
            fetch_valid       <= 1'b0;
            fetch_instruction <= 32'd0;
            fetch_pc          <= 32'd0;
            fetch_adel        <= 1'b0;
            fetch_ibe         <= 1'b0;
        end else if (load) begin
            pc          <= load_pc;
            fetch_valid <= 1'b0;
            fetch_adel  <= 1'b0;
            fetch_ibe   <= 1'b0;
            // Any response still owed by memory must be drained before a new request.
            if (((state == StWait) || (state == StDrop)) && !imem_rvalid) begin
                state <= StDrop;
            end else if (imem_req && imem_ack) begin
                state <= StDrop;
            end else begin
                state <= StReq;
            end
        end else begin
            if (consume) begin
                fetch_valid <= 1'b0;
            end
            unique case (state)
                StIdle: begin
                    if (buffer_free) begin
                        state <= StReq;
                    end
                end
                StReq: begin
                    if (pc_misaligned) begin
                        if (buffer_free) begin
                            fetch_valid       <= 1'b1;
                            fetch_instruction <= 32'd0;
                            fetch_pc          <= pc;
                            fetch_adel        <= 1'b1;
                            fetch_ibe         <= 1'b0;
                            state             <= StIdle;
                        end
                    end else if (imem_ack) begin
                        req_pc <= pc;
                        pc     <= pc + 32'd4;
                        state  <= StWait;
                    end
                end
                StWait: begin
                    if (imem_rvalid) begin
                        fetch_valid       <= 1'b1;
                        fetch_instruction <= imem_rdata;
                        fetch_pc          <= req_pc;
                        fetch_adel        <= 1'b0;
                        fetch_ibe         <= imem_err;
                        state             <= consume ? StReq : StIdle;
                    end
                end
                StDrop: begin
                    if (imem_rvalid) begin
                        state <= StReq;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch stage sitting directly downstream of the pipeline flow controller and upstream of the decode pipeline register.
- Owns the fetch PC and applies redirects (load/pc) from the controller.
- Runs a single-outstanding request/response transaction with instruction memory and holds one fetched instruction for decode.
- Reports instruction_memory_busy back to the controller whenever no instruction is ready for decode.

Parameters:
- RESET_PC, 32'hBFC0_0000, fetch address after reset (MIPS reset vector).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- load  input  1  redirect request from the flow controller.
- load_pc  input  32  redirect target, valid while load=1.
- stall_fetch  input  1  decode must not consume this cycle.
- imem_req  output  1  instruction memory request valid.
- imem_addr  output  32  request address, word aligned.
- imem_ack  input  1  request accepted this cycle.
- imem_rvalid  input  1  response valid.
- imem_rdata  input  32  response instruction word.
- imem_err  input  1  bus error, qualified by imem_rvalid.
- fetch_valid  output  1  buffer holds an instruction for decode.
- fetch_instruction  output  32  buffered instruction.
- fetch_pc  output  32  address of the buffered instruction.
- fetch_pc_plus4  output  32  fetch_pc + 4, wraps modulo 2^32.
- fetch_adel  output  1  fetch address misaligned (pc[1:0] != 0).
- fetch_ibe  output  1  instruction bus error on this fetch.
- instruction_memory_busy  output  1  equal to ~fetch_valid.

Behaviour:
- Reset (async, reset_n=0):
  - pc=RESET_PC, state=S_IDLE, imem_req=0.
  - fetch_valid=0, fetch_instruction=0, fetch_pc=0, fetch_adel=0, fetch_ibe=0.
  - instruction_memory_busy=1.
  - A reset mid-transaction abandons it; any later stray imem_rvalid is ignored until a new request is accepted.
- Consume: at a clock edge where fetch_valid=1 and stall_fetch=0, decode latches the buffer and the buffer empties. The buffer refills in the same edge if a response lands.
- stall_fetch only blocks consumption. It never blocks memory traffic; this prevents deadlock, because the controller raises stall_fetch in response to busy.
- States:
  - S_IDLE: buffer full and not being consumed. imem_req=0. Moves to S_REQ when the buffer empties or is consumed this cycle.
  - S_REQ: imem_req=1, imem_addr=pc. Requires pc[1:0]==0.
    - If pc is misaligned: no request is issued. The buffer fills next edge with instruction=0, fetch_adel=1, fetch_pc=pc. pc is held. State goes to S_IDLE.
    - imem_ack=1 -> S_WAIT, req_pc<=pc, pc<=pc+4.
    - imem_addr/imem_req stay stable until ack.
  - S_WAIT: imem_req=0. On imem_rvalid:
    - Buffer loads rdata; fetch_pc=req_pc; fetch_ibe=imem_err; fetch_adel=0.
    - Next state is S_REQ if the buffer is being consumed that same edge, else S_IDLE.
    - Response latency is at least 1 cycle after ack.
  - S_DROP: waiting for a response that a redirect killed. imem_req=0. On imem_rvalid, discard the data and go to S_REQ.
- Redirect (load=1) has highest priority over every other event at the edge:
  - pc<=load_pc; buffer invalidated (fetch_valid=0, adel/ibe cleared).
  - From S_WAIT, or S_REQ with ack this cycle: next state is S_DROP, unless imem_rvalid arrives the same cycle in S_WAIT, in which case that data is discarded and next state is S_REQ.
  - Otherwise next state is S_REQ.
  - load applies every cycle it is high, even with stall_fetch=1. A repeated identical load re-invalidates and restarts; this is legal.
- Throughput: one instruction per (ack latency + response latency) cycles. There is no prefetch beyond one outstanding request.
- Arithmetic: all PC adds are 32-bit and wrap (32'hFFFF_FFFC+4=0).

Test Plan:
- Reset, then 1-cycle ack and 1-cycle rvalid memory, stall_fetch=0:
  - First imem_addr=BFC0_0000, then BFC0_0004, BFC0_0008.
  - fetch_valid pulses carry the matching fetch_pc.
  - busy=0 only while fetch_valid=1.
- Buffer full with stall_fetch=1 for 5 cycles:
  - fetch_instruction and fetch_pc are held.
  - imem_req=0 throughout.
  - After release, the next request is pc+4.
- load=1, load_pc=0000_0100 while in S_WAIT for addr BFC0_0008, with rvalid 3 cycles later carrying 0xDEADBEEF:
  - 0xDEADBEEF is never presented.
  - Next imem_addr=0000_0100.
- load_pc=0000_0102:
  - No imem_req is issued.
  - Buffer gets fetch_adel=1, fetch_pc=0000_0102, instruction=0.
  - Holds until the next load.
- Response with imem_err=1 at addr 0000_0200 -> fetch_ibe=1, fetch_pc=0000_0200. The next fetch has fetch_ibe=0.
- reset_n pulsed low during S_WAIT:
  - Outputs return to reset values immediately (async).
  - The stale rvalid is ignored.
  - The first request is RESET_PC.
